// File: rtl/display_pkg.sv
// Shared widths and digit helpers for the two-digit display path.
// Consumers: switch_press_counter (and its BCD option, SWITCH_PRESS_COUNTER_BCD_EN).
package display_pkg;

    localparam int DIGIT_W = 4;
    localparam int COUNT_W = 8;
    localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

    // Two-digit BCD increment, 99 rolls over to 00.
    function automatic logic [COUNT_W-1:0] bcd_inc(input logic [COUNT_W-1:0] value);
        logic [DIGIT_W-1:0] hi;
        logic [DIGIT_W-1:0] lo;
        hi = value[COUNT_W-1:DIGIT_W];
        lo = value[DIGIT_W-1:0];
        if (lo >= BCD_MAX_DIGIT) begin
            lo = '0;
            hi = (hi >= BCD_MAX_DIGIT) ? '0 : hi + DIGIT_W'(1);
        end else begin
            lo = lo + DIGIT_W'(1);
        end
        return {hi, lo};
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser plus a restartable debounce window for one raw button level.
module debounce_filter #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             stable;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            s1 <= i_raw;
            s2 <= s1;
            // Any sample that agrees with the stable level restarts the window.
            if (s2 != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= s2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign o_stable = stable;

endmodule

// File: rtl/switch_press_counter.sv
// Debounced push-button press counter feeding a two-digit seven-segment display.
// Define SWITCH_PRESS_COUNTER_BCD_EN for a 00-99 BCD count; default is an 8-bit hex count.
module switch_press_counter
    import display_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_switch,
    input  logic               i_clear,
    output logic [DIGIT_W-1:0] o_digit_hi,
    output logic [DIGIT_W-1:0] o_digit_lo,
    output logic               o_press_pulse
);

    logic               stable;
    logic               stable_d;
    logic               rise;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_next;
    logic               press_pulse;

    debounce_filter #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_debounce (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_raw   (i_switch),
        .o_stable(stable)
    );

    assign rise = stable & ~stable_d;

`ifdef SWITCH_PRESS_COUNTER_BCD_EN
    assign count_next = bcd_inc(count);
`else
    assign count_next = count + COUNT_W'(1);
`endif

    // Clear wins over a coinciding press; that press is dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stable_d    <= 1'b0;
            count       <= '0;
            press_pulse <= 1'b0;
        end else begin
            stable_d <= stable;
            if (i_clear) begin
                count       <= '0;
                press_pulse <= 1'b0;
            end else if (rise) begin
                count       <= count_next;
                press_pulse <= 1'b1;
            end else begin
                press_pulse <= 1'b0;
            end
        end
    end

    assign o_digit_hi    = count[COUNT_W-1:DIGIT_W];
    assign o_digit_lo    = count[DIGIT_W-1:0];
    assign o_press_pulse = press_pulse;

endmodule

// File: doc/switch_press_counter.md
Name: switch_press_counter

Overview:
- Upstream stage for a pair of seven_segment decoders on the two-digit display.
- Synchronises and debounces one raw push-button input and counts debounced presses.
- Presents the count as two 4-bit digit values: high digit and low digit, one per decoder.
- Also emits a one-cycle press strobe for other consumers.

Parameters:
- DEBOUNCE_LIMIT, 250000, number of consecutive cycles the synchronised input must differ from the stable state before the stable state flips (10 ms at 25 MHz); legal range >= 2.

Ports:
- i_clk  input  1  system clock, all logic on rising edge
- i_rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to i_clk upstream
- i_switch  input  1  raw, asynchronous, bouncing push-button level (1 = pressed)
- i_clear  input  1  synchronous clear of the press count, sampled each cycle
- o_digit_hi  output  4  upper digit of the count, to the tens/high seven_segment i_value
- o_digit_lo  output  4  lower digit of the count, to the ones/low seven_segment i_value
- o_press_pulse  output  1  high for exactly one cycle when a debounced press is counted

Behaviour:
- Reset (i_rst_n = 0, async): sync flops, debounce counter, stable state, edge register, count and o_press_pulse all go to 0. o_digit_hi = o_digit_lo = 4'h0.
- Synchroniser: two flops s1 <= i_switch, s2 <= s1. No other logic samples i_switch.
- Debounce counter: cnt, width $clog2(DEBOUNCE_LIMIT). Each cycle:
  - if s2 != stable and cnt == DEBOUNCE_LIMIT-1: stable <= s2, cnt <= 0;
  - else if s2 != stable: cnt <= cnt+1;
  - else: cnt <= 0 (any bounce back restarts the window).
- Edge detect: stable_d <= stable. rise = stable & ~stable_d. Releases (falling edges of stable) are never counted.
- Count: 8-bit register {hi, lo}. Outputs are driven directly from this register; there is no combinational path from inputs to outputs.
  - On rise: count increments and o_press_pulse <= 1.
  - Otherwise: o_press_pulse <= 0.
- Latency: i_switch goes high and stays high, first sampled at edge 0.
  - s2 is set at edge 1.
  - stable is set at edge DEBOUNCE_LIMIT+1.
  - The new count and o_press_pulse appear after edge DEBOUNCE_LIMIT+2.
- Hex mode (default): count wraps 0xFF -> 0x00. o_press_pulse still fires on the wrapping press.
- i_clear:
  - count <= 0 on the next edge and o_press_pulse <= 0.
  - Clear has priority when it coincides with rise: that press is dropped, result 0x00.
  - Debounce state is not affected, so a press in progress completes normally.
- Held button: exactly one count per debounced press, regardless of hold duration.
- Reset mid-debounce: the partial window is discarded. After reset release with the button still held, the press is counted once after the full latency, because stable restarts at 0.

Optional Feature:
- Macro: SWITCH_PRESS_COUNTER_BCD_EN.
- Defined: count is two BCD digits 00-99.
  - lo 9 -> 0 with hi+1.
  - 99 -> 00.
  - Digits never exceed 4'd9.
- Undefined: plain 8-bit binary count 0x00-0xFF. hi/lo are the upper and lower nibbles.

Decomposition:
- Shared package (display_pkg): DIGIT_W = 4, COUNT_W = 8, BCD_MAX_DIGIT = 4'd9.
- Natural sub-module: debounce_filter.
  - Contains the synchroniser, debounce counter and stable flop.
  - Parameter DEBOUNCE_LIMIT; ports i_clk, i_rst_n, i_raw, o_stable.
- The top level holds the edge detect, the counter, the clear logic and the BCD option.

Test Plan (DEBOUNCE_LIMIT = 4):
- Reset: assert i_rst_n = 0 mid-run -> all outputs 0 immediately (async). After release, hi = 0, lo = 0, o_press_pulse = 0.
- Clean press: i_switch 0 -> 1 held 20 cycles -> o_press_pulse high exactly one cycle, 6 edges after first sampling; count 0x01; no further pulses while held or on release.
- Bounce: i_switch toggles every 2 cycles for 16 cycles, then held high -> no count during bouncing; exactly one increment after 4 stable synced cycles.
- Wrap: 256 clean presses in hex mode -> 0xFF then 0x00, with a pulse on every press. In BCD build, 100 presses -> 0x99 then 0x00, and lo never shows 0xA-0xF.
- Clear collision: i_clear asserted in the same cycle that rise is high, with count 0x05 -> count 0x00 and o_press_pulse stays 0. The next clean press -> 0x01.
- Reset mid-debounce: button held, reset pulsed when cnt = 2, button still held after release -> one count after full latency from release, count 0x01.
